// File: rtl/uart_cmd_framer.sv
// Frames UART receiver bytes into debugger commands (opcode, address, data)
// and presents each one on a valid/ready handshake, aborting stalled frames.
module uart_cmd_framer #(
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Cmd_Ready,
    output logic        o_Cmd_Valid,
    output logic [7:0]  o_Cmd_Op,
    output logic [31:0] o_Cmd_Addr,
    output logic [31:0] o_Cmd_Data,
    output logic        o_Busy,
    output logic        o_Err_Timeout,
    output logic        o_Err_Overrun
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t          state, state_nx;
    logic [1:0]      byte_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            in_frame;
    logic            tmo_hit;
    logic            has_operands;

    assign in_frame     = (state == ADDR) || (state == DATA);
    // A byte in the same cycle as the last allowed count wins over the timeout.
    assign tmo_hit      = in_frame && !i_Rx_DV && (tmo_cnt == T_LAST);
    assign has_operands = (i_Rx_Byte[7:6] == 2'b01) || (i_Rx_Byte[7:6] == 2'b10);

    assign o_Cmd_Valid  = (state == HOLD);
    assign o_Busy       = (state != IDLE);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_Rx_DV) begin
                    state_nx = has_operands ? ADDR : HOLD;
                end
            end
            ADDR: begin
                if (i_Rx_DV) begin
                    if (byte_cnt == 2'd3) begin
                        // Only class 10 reaches ADDR with op[7] set.
                        state_nx = o_Cmd_Op[7] ? DATA : HOLD;
                    end
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                end
            end
            DATA: begin
                if (i_Rx_DV) begin
                    if (byte_cnt == 2'd3) begin
                        state_nx = HOLD;
                    end
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                end
            end
            HOLD: begin
                if (i_Cmd_Ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Cmd_Op      <= '0;
            o_Cmd_Addr    <= '0;
            o_Cmd_Data    <= '0;
            o_Err_Timeout <= 1'b0;
            o_Err_Overrun <= 1'b0;
            byte_cnt      <= '0;
            tmo_cnt       <= '0;
        end else begin
            o_Err_Timeout <= tmo_hit;
            o_Err_Overrun <= (state == HOLD) && i_Rx_DV;

            if (!in_frame || i_Rx_DV || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + T_ONE;
            end

            case (state)
                IDLE: begin
                    if (i_Rx_DV) begin
                        o_Cmd_Op   <= i_Rx_Byte;
                        o_Cmd_Addr <= '0;
                        o_Cmd_Data <= '0;
                        byte_cnt   <= '0;
                    end
                end
                ADDR: begin
                    if (i_Rx_DV) begin
                        o_Cmd_Addr <= {o_Cmd_Addr[23:0], i_Rx_Byte};
                        byte_cnt   <= byte_cnt + 2'd1;
                    end
                end
                DATA: begin
                    if (i_Rx_DV) begin
                        o_Cmd_Data <= {o_Cmd_Data[23:0], i_Rx_Byte};
                        byte_cnt   <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Assembles the byte stream from the UART receiver into fixed-format debugger commands (opcode, optional 32-bit address, optional 32-bit data). Sits between the UART receiver's byte-valid output and the debugger's command controller. Presents each complete command with a valid/ready handshake. Aborts partial frames after an inter-byte timeout, so a dropped byte cannot desynchronise the link.

## Interface
Parameters:
- TIMEOUT_CLKS, default 1000000: maximum number of clocks allowed between bytes inside a frame. Must be ≥ 2.

Ports:
- i_Clock  in  1  system clock; all logic is clocked on its rising edge
- i_Reset_n  in  1  reset, asynchronous and active-low
- i_Rx_DV  in  1  one-cycle byte-valid pulse from the UART receiver
- i_Rx_Byte  in  8  received byte; valid only when i_Rx_DV=1
- i_Cmd_Ready  in  1  downstream accepts the command
- o_Cmd_Valid  out  1  a complete command is presented
- o_Cmd_Op  out  8  opcode byte
- o_Cmd_Addr  out  32  address operand
- o_Cmd_Data  out  32  data operand
- o_Busy  out  1  a frame is in progress or a command is held
- o_Err_Timeout  out  1  one-cycle pulse when a frame is aborted by timeout
- o_Err_Overrun  out  1  one-cycle pulse when a byte is dropped while a command is held

## Operation
- Frame format: the opcode byte comes first.
  - op[7:6]=00: no operands.
  - op[7:6]=01: 4 address bytes follow.
  - op[7:6]=10: 4 address bytes, then 4 data bytes, follow.
  - op[7:6]=11: treated like 00 and forwarded unchanged; downstream rejects it.
- Operands are sent MSB first. Each accepted byte shifts into the low byte of its operand register: reg <= {reg[23:0], byte}.
- State machine states: IDLE, ADDR, DATA, HOLD.
- IDLE, on i_Rx_DV:
  - Latch o_Cmd_Op.
  - Clear o_Cmd_Addr and o_Cmd_Data to 0.
  - Clear the 2-bit byte counter.
  - Next state is HOLD for class 00/11, or ADDR for class 01/10.
- ADDR, on i_Rx_DV: shift the byte into o_Cmd_Addr and increment the counter. On the 4th byte (counter=3), clear the counter; next state is DATA for class 10, otherwise HOLD.
- DATA, on i_Rx_DV: shift the byte into o_Cmd_Data. On the 4th byte, next state is HOLD.
- HOLD:
  - o_Cmd_Valid=1.
  - When o_Cmd_Valid & i_Cmd_Ready, return to IDLE on the next edge.
  - o_Cmd_Op, o_Cmd_Addr and o_Cmd_Data are stable throughout HOLD. They keep their values after the handshake until the next opcode byte.
- Overrun: an i_Rx_DV in HOLD is dropped and o_Err_Overrun pulses. This applies even in the handshake cycle. The dropped byte is never interpreted as an opcode.
- Timeout:
  - The counter is $clog2(TIMEOUT_CLKS) bits wide.
  - It is cleared on every accepted byte and on entry to ADDR.
  - It increments every cycle in ADDR/DATA and is held at 0 in IDLE/HOLD.
  - If it reaches TIMEOUT_CLKS-1 with no byte in that cycle: pulse o_Err_Timeout, go to IDLE, and never assert o_Cmd_Valid for that frame.
  - If a byte arrives in the same cycle the counter reaches TIMEOUT_CLKS-1, the byte wins and no timeout occurs.
- o_Busy = (state != IDLE).
- Reset mid-frame discards all partial state.

## Timing
- Reset value of every output is 0, as is the state (IDLE) and all counters.
- Reset takes effect immediately, asynchronously, and is released synchronously to i_Clock.
- Latency: the final byte's i_Rx_DV at edge N gives o_Cmd_Valid=1 after edge N, with no combinational path from i_Rx_DV.
  - Class 00: valid is asserted the cycle after the opcode.
- Valid/ready:
  - o_Cmd_Valid must not drop and the payload must not change until the handshake.
  - i_Cmd_Ready may be held high in advance. The handshake then happens in the first HOLD cycle, so valid is high for exactly 1 cycle.
- Error pulses last exactly 1 cycle and are registered.
- Back-to-back bytes on consecutive cycles must be accepted, even though the receiver never produces them.
- Throughput: one command per frame. The next opcode is accepted from the cycle after the handshake (the IDLE cycle).

## Test plan
- Reset, then idle 100 cycles → all outputs 0, o_Busy=0, no error pulses.
- Bytes 0x41, 0xDE, 0xAD, 0xBE, 0xEF with i_Cmd_Ready=1 → one valid cycle with Op=0x41, Addr=0xDEADBEEF, Data=0.
- Bytes 0x82, 0x00, 0x00, 0x10, 0x04, 0x12, 0x34, 0x56, 0x78 with i_Cmd_Ready low for 20 cycles → valid held with a stable payload of Addr=0x00001004 and Data=0x12345678. A byte sent during HOLD gives o_Err_Overrun=1 for 1 cycle and the payload stays unchanged.
- Bytes 0x41, 0x11, 0x22, then silence for TIMEOUT_CLKS=16 → o_Err_Timeout pulses 16 cycles after byte 0x22, then IDLE, no valid. A following 0x05 gives Op=0x05 valid the next cycle.
- A byte arriving exactly at count TIMEOUT_CLKS-1 → accepted, no timeout. Single opcode 0xC3 → forwarded with Addr=Data=0.
- i_Reset_n asserted after 2 address bytes → outputs 0 immediately. After release, a full 0x41 frame decodes correctly.
